aidc_lite_code_arbiter: RTL and testbench

AIDC_LITE_CODE_ARBITER -- requirements
Module: AIDC_LITE_CODE_ARBITER

---
 rtl/aidc_lite_code_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_aidc_lite_code_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aidc_lite_code_arbiter.sv
// rtl/aidc_lite_code_arbiter.sv - round-robin arbiter sharing one code-concatenate unit among block requesters
module aidc_lite_code_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int DATA_SIZE = 66,
    parameter int TIMEOUT   = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    input  logic [NUM_REQ-1:0]             req_sop_i,
    input  logic [NUM_REQ-1:0]             req_eop_i,
    input  logic [NUM_REQ*DATA_SIZE-1:0]   req_data_i,
    input  logic [NUM_REQ*7-1:0]           req_size_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    output logic                           valid_o,
    output logic                           sop_o,
    output logic                           eop_o,
    output logic [DATA_SIZE-1:0]           data_o,
    output logic [6:0]                     size_o,
    input  logic                           cc_done_i,
    input  logic                           cc_fail_i,
    output logic                           blk_done_o,
    output logic                           blk_fail_o,
    output logic [2:0]                     blk_id_o,
    output logic                           err_o
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_WAIT_DONE
    } state_t;

    state_t                 r_state;
    logic [2:0]             r_grant;
    logic [2:0]             r_last_grant;
    logic [NUM_REQ-1:0]     r_ready;
    logic                   r_first;
    logic                   r_done_seen_low;
    logic [CW-1:0]          r_cnt;
    logic                   r_valid;
    logic                   r_sop;
    logic                   r_eop;
    logic [DATA_SIZE-1:0]   r_data;
    logic [6:0]             r_size;
    logic                   r_blk_done;
    logic                   r_blk_fail;
    logic [2:0]             r_blk_id;
    logic                   r_err;

    logic [NUM_REQ-1:0]     w_cand;
    logic                   w_bad_idle;
    logic                   w_found;
    logic [2:0]             w_pick;
    logic [NUM_REQ-1:0]     w_pick_oh;
    logic                   w_accept;
    logic                   w_sop;
    logic                   w_eop;
    logic [DATA_SIZE-1:0]   w_data;
    logic [6:0]             w_size;

    assign w_cand     = req_valid_i & req_sop_i;
    assign w_bad_idle = |(req_valid_i & ~req_sop_i);

    // Round robin: scan requesters above last_grant first, then wrap to the low ones.
    always_comb begin
        w_found   = 1'b0;
        w_pick    = '0;
        w_pick_oh = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!w_found && w_cand[j] && (3'(j) > r_last_grant)) begin
                w_found = 1'b1;
                w_pick  = 3'(j);
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!w_found && w_cand[j] && (3'(j) <= r_last_grant)) begin
                w_found = 1'b1;
                w_pick  = 3'(j);
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            w_pick_oh[j] = (3'(j) == w_pick);
        end
    end

    always_comb begin
        w_accept = 1'b0;
        w_sop    = 1'b0;
        w_eop    = 1'b0;
        w_data   = '0;
        w_size   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (3'(k) == r_grant) begin
                w_accept = req_valid_i[k] & r_ready[k] & (r_state == S_STREAM);
                w_sop    = req_sop_i[k];
                w_eop    = req_eop_i[k];
                w_data   = req_data_i[k*DATA_SIZE +: DATA_SIZE];
                w_size   = req_size_i[k*7 +: 7];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_grant         <= '0;
            r_last_grant    <= 3'(NUM_REQ - 1);
            r_ready         <= '0;
            r_first         <= 1'b0;
            r_done_seen_low <= 1'b0;
            r_cnt           <= '0;
            r_valid         <= 1'b0;
            r_sop           <= 1'b0;
            r_eop           <= 1'b0;
            r_data          <= '0;
            r_size          <= '0;
            r_blk_done      <= 1'b0;
            r_blk_fail      <= 1'b0;
            r_blk_id        <= '0;
            r_err           <= 1'b0;
        end else begin
            r_valid    <= 1'b0;
            r_sop      <= 1'b0;
            r_eop      <= 1'b0;
            r_blk_done <= 1'b0;
            r_blk_fail <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_bad_idle) begin
                        r_err <= 1'b1;
                    end
                    if (w_found) begin
                        r_grant         <= w_pick;
                        r_ready         <= w_pick_oh;
                        r_first         <= 1'b1;
                        r_done_seen_low <= 1'b0;
                        r_state         <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (!cc_done_i) begin
                        r_done_seen_low <= 1'b1;
                    end
                    if (w_accept) begin
                        r_valid <= 1'b1;
                        r_sop   <= w_sop;
                        r_eop   <= w_eop;
                        r_data  <= w_data;
                        r_size  <= w_size;
                        r_first <= 1'b0;
                        // A second sop inside a block is passed through but flagged.
                        if (w_sop && !r_first) begin
                            r_err <= 1'b1;
                        end
                        if (w_eop) begin
                            r_ready <= '0;
                            r_cnt   <= '0;
                            r_state <= S_WAIT_DONE;
                        end
                    end
                end
                S_WAIT_DONE: begin
                    if (!cc_done_i) begin
                        r_done_seen_low <= 1'b1;
                    end
                    // A done level is trusted only after it has dropped once for this block.
                    if (r_done_seen_low && cc_done_i) begin
                        r_blk_done   <= 1'b1;
                        r_blk_fail   <= cc_fail_i;
                        r_blk_id     <= r_grant;
                        r_last_grant <= r_grant;
                        r_state      <= S_IDLE;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_blk_done <= 1'b1;
                        r_blk_fail <= 1'b1;
                        r_blk_id   <= r_grant;
                        r_err      <= 1'b1;
                        r_state    <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o = r_ready;
    assign valid_o     = r_valid;
    assign sop_o       = r_sop;
    assign eop_o       = r_eop;
    assign data_o      = r_data;
    assign size_o      = r_size;
    assign blk_done_o  = r_blk_done;
    assign blk_fail_o  = r_blk_fail;
    assign blk_id_o    = r_blk_id;
    assign err_o       = r_err;

endmodule

// File: tb/tb_aidc_lite_code_arbiter.sv
// tb/tb_aidc_lite_code_arbiter.sv - directed self-checking bench for aidc_lite_code_arbiter
module tb_aidc_lite_code_arbiter;

    localparam int NR = 2;
    localparam int DS = 66;
    localparam int TO = 32;

    logic                clk = 1'b0;
    logic                rst;
    logic [NR-1:0]       req_valid_i;
    logic [NR-1:0]       req_sop_i;
    logic [NR-1:0]       req_eop_i;
    logic [NR*DS-1:0]    req_data_i;
    logic [NR*7-1:0]     req_size_i;
    logic [NR-1:0]       req_ready_o;
    logic                valid_o;
    logic                sop_o;
    logic                eop_o;
    logic [DS-1:0]       data_o;
    logic [6:0]          size_o;
    logic                cc_done_i;
    logic                cc_fail_i;
    logic                blk_done_o;
    logic                blk_fail_o;
    logic [2:0]          blk_id_o;
    logic                err_o;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [DS-1:0] D0 = 66'h3_FEDC_BA98_7654_3210;
    localparam logic [DS-1:0] D1 = 66'h1_0123_4567_89AB_CDEF;
    localparam logic [DS-1:0] D2 = 66'h2_5555_AAAA_0F0F_F0F0;
    localparam logic [DS-1:0] A0 = 66'h0_0000_0000_0000_00A0;
    localparam logic [DS-1:0] B1 = 66'h3_0000_0000_0000_00B1;

    aidc_lite_code_arbiter #(
        .NUM_REQ   (NR),
        .DATA_SIZE (DS),
        .TIMEOUT   (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid_i),
        .req_sop_i   (req_sop_i),
        .req_eop_i   (req_eop_i),
        .req_data_i  (req_data_i),
        .req_size_i  (req_size_i),
        .req_ready_o (req_ready_o),
        .valid_o     (valid_o),
        .sop_o       (sop_o),
        .eop_o       (eop_o),
        .data_o      (data_o),
        .size_o      (size_o),
        .cc_done_i   (cc_done_i),
        .cc_fail_i   (cc_fail_i),
        .blk_done_o  (blk_done_o),
        .blk_fail_o  (blk_fail_o),
        .blk_id_o    (blk_id_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic v, input logic s, input logic e,
                           input logic [DS-1:0] d, input logic [6:0] sz);
        req_valid_i[k]         = v;
        req_sop_i[k]           = s;
        req_eop_i[k]           = e;
        req_data_i[k*DS +: DS] = d;
        req_size_i[k*7 +: 7]   = sz;
    endtask

    task automatic clr_req();
        req_valid_i = '0;
        req_sop_i   = '0;
        req_eop_i   = '0;
        req_data_i  = '0;
        req_size_i  = '0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        clr_req();
        cc_done_i = 1'b1;
        cc_fail_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        clr_req();
        cc_done_i = 1'b1;
        cc_fail_i = 1'b0;

        // Reset state
        do_reset();
        check("rst_ready", req_ready_o, 2'b00);
        check("rst_valid", valid_o, 1'b0);
        check("rst_sop_eop", {sop_o, eop_o}, 2'b00);
        check("rst_data", data_o, '0);
        check("rst_size", size_o, 7'd0);
        check("rst_blk", {blk_done_o, blk_fail_o, blk_id_o}, 5'b0);
        check("rst_err", err_o, 1'b0);

        // Three-beat block from req0, delayed done with fail
        set_req(0, 1'b1, 1'b1, 1'b0, D0, 7'd6);
        tick();
        check("t1_ready_grant", req_ready_o, 2'b01);
        check("t1_no_valid_yet", valid_o, 1'b0);
        tick();
        check("t1_b0_frame", {valid_o, sop_o, eop_o}, 3'b110);
        check("t1_b0_data", data_o, D0);
        check("t1_b0_size", size_o, 7'd6);
        set_req(0, 1'b1, 1'b0, 1'b0, D1, 7'd34);
        tick();
        check("t1_b1_frame", {valid_o, sop_o, eop_o}, 3'b100);
        check("t1_b1_data", data_o, D1);
        check("t1_b1_size", size_o, 7'd34);
        set_req(0, 1'b1, 1'b0, 1'b1, D2, 7'd34);
        cc_done_i = 1'b0;
        tick();
        check("t1_b2_frame", {valid_o, sop_o, eop_o}, 3'b101);
        check("t1_b2_data", data_o, D2);
        check("t1_wait_ready", req_ready_o, 2'b00);
        clr_req();
        tick();
        check("t1_idle_valid", valid_o, 1'b0);
        check("t1_data_hold", data_o, D2);
        check("t1_blk_early1", blk_done_o, 1'b0);
        tick();
        check("t1_blk_early2", blk_done_o, 1'b0);
        tick();
        cc_done_i = 1'b1;
        cc_fail_i = 1'b1;
        check("t1_blk_early3", blk_done_o, 1'b0);
        tick();
        check("t1_blk_done", {blk_done_o, blk_fail_o, blk_id_o}, 5'b11_000);
        cc_fail_i = 1'b0;
        tick();
        check("t1_blk_pulse_end", {blk_done_o, blk_fail_o, blk_id_o}, 5'b00_000);
        check("t1_err_clean", err_o, 1'b0);

        // Simultaneous sop from req0 and req1 after reset
        do_reset();
        cc_done_i = 1'b0;
        set_req(0, 1'b1, 1'b1, 1'b1, A0, 7'd10);
        set_req(1, 1'b1, 1'b1, 1'b1, B1, 7'd20);
        tick();
        check("t2_grant0", req_ready_o, 2'b01);
        tick();
        check("t2_a_frame", {valid_o, sop_o, eop_o}, 3'b111);
        check("t2_a_data", {size_o, data_o}, {7'd10, A0});
        check("t2_a_wait_ready", req_ready_o, 2'b00);
        set_req(0, 1'b0, 1'b0, 1'b0, '0, 7'd0);
        cc_done_i = 1'b1;
        tick();
        check("t2_a_done", {blk_done_o, blk_fail_o, blk_id_o}, 5'b10_000);
        check("t2_no_ready_in_done", req_ready_o, 2'b00);
        tick();
        check("t2_grant1", req_ready_o, 2'b10);
        cc_done_i = 1'b0;
        tick();
        check("t2_b_frame", {valid_o, sop_o, eop_o}, 3'b111);
        check("t2_b_data", {size_o, data_o}, {7'd20, B1});
        clr_req();
        cc_done_i = 1'b1;
        tick();
        check("t2_b_done", {blk_done_o, blk_fail_o, blk_id_o}, 5'b10_001);

        // Timeout with done held low
        cc_done_i = 1'b0;
        set_req(0, 1'b1, 1'b1, 1'b1, D1, 7'd3);
        tick();
        check("t3_grant0", req_ready_o, 2'b01);
        tick();
        check("t3_frame", {valid_o, sop_o, eop_o}, 3'b111);
        clr_req();
        for (int i = 0; i < TO; i++) begin
            check($sformatf("t3_no_done_%0d", i), blk_done_o, 1'b0);
            tick();
        end
        check("t3_timeout", {blk_done_o, blk_fail_o, blk_id_o}, 5'b11_000);
        check("t3_err", err_o, 1'b1);
        tick();
        check("t3_after", {blk_done_o, blk_fail_o, err_o}, 3'b001);
        check("t3_idle_ready", req_ready_o, 2'b00);

        // Valid without sop while idle
        do_reset();
        cc_done_i = 1'b1;
        set_req(1, 1'b1, 1'b0, 1'b0, B1, 7'd9);
        tick();
        check("t4_ready", req_ready_o, 2'b00);
        check("t4_err", err_o, 1'b1);
        check("t4_valid", valid_o, 1'b0);
        tick();
        check("t4_valid2", valid_o, 1'b0);
        check("t4_ready2", req_ready_o, 2'b00);

        // Extra sop inside a block, then reset mid-stream
        do_reset();
        set_req(0, 1'b1, 1'b1, 1'b0, D0, 7'd5);
        tick();
        tick();
        check("t5_b0_valid", {valid_o, sop_o}, 2'b11);
        check("t5_err_clear", err_o, 1'b0);
        set_req(0, 1'b1, 1'b1, 1'b0, D2, 7'd7);
        tick();
        check("t5_b1_fwd", {valid_o, sop_o, eop_o}, 3'b110);
        check("t5_b1_data", data_o, D2);
        check("t5_err_sop", err_o, 1'b1);
        rst = 1'b1;
        tick();
        check("t5_rst_ready", req_ready_o, 2'b00);
        check("t5_rst_frame", {valid_o, sop_o, eop_o}, 3'b000);
        check("t5_rst_data", {size_o, data_o}, '0);
        check("t5_rst_blk", {blk_done_o, blk_fail_o, blk_id_o, err_o}, 6'b0);
        rst = 1'b0;
        set_req(0, 1'b1, 1'b1, 1'b0, A0, 7'd1);
        set_req(1, 1'b1, 1'b1, 1'b0, B1, 7'd2);
        tick();
        check("t5_tie_req0", req_ready_o, 2'b01);
        check("t5_no_blk", blk_done_o, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
